xgmii_tx_width_adapter: RTL

Buffers 64-bit XGMII words (8 control bits) from the MAC TX path and replays them to the PCS at a parametrised lane width of 32 or 64 bits. The PCS side uses a valid/pause handshake. The block fills empty slots with XGMII idle and converts a mid-frame underrun into an error column so the PCS never sees a truncated frame. It sits between the MAC TX datapath and the PCS 64b/66b encoder/gearbox.

---
 rtl/xgmii_pkg.sv | 25 ++
 rtl/xgmii_word_fifo.sv | 48 ++++
 rtl/xgmii_tx_width_adapter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants, the buffered word type and a lane-fill helper
// for the TX width adapter.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } xgmii_word_t;

  // Places one control character in each of the lowest n_lanes byte lanes; upper lanes stay zero.
  function automatic logic [63:0] replicate_ctrl(input logic [7:0] ch, input int n_lanes);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n_lanes) w[i*8 +: 8] = ch;
    end
    return w;
  endfunction

endpackage

// File: rtl/xgmii_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed XGMII words.
// Writes are ignored when full and reads are ignored when empty.
module xgmii_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 72
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one wrap bit so full and empty are distinguishable without a counter.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/xgmii_tx_width_adapter.sv
// Buffers 64-bit MAC TX words and replays them to the PCS as 32- or 64-bit slots,
// filling gaps with idle and closing underrun frames with an error column.
module xgmii_tx_width_adapter
  import xgmii_pkg::*;
#(
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int IDLE_FILL  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [63:0]                   s_txd,
  input  logic [7:0]                    s_txc,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [OUT_WIDTH-1:0]          o_xgmii_txd,
  output logic [OUT_WIDTH/8-1:0]        o_xgmii_txc,
  output logic                          o_xgmii_valid,
  input  logic                          i_xgmii_pause,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_underrun
);

  localparam int                   CW        = OUT_WIDTH / 8;
  localparam logic [63:0]          IDLE_WORD = replicate_ctrl(XGMII_IDLE, CW);
  localparam logic [63:0]          ERR_WORD  = replicate_ctrl(XGMII_ERROR, CW);
  localparam logic [OUT_WIDTH-1:0] IDLE_SLOT = IDLE_WORD[OUT_WIDTH-1:0];
  localparam logic [OUT_WIDTH-1:0] ERR_SLOT  = ERR_WORD[OUT_WIDTH-1:0];

  xgmii_word_t          wr_word;
  xgmii_word_t          head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 advance;
  logic                 half_sel;
  logic                 in_frame;
  logic [OUT_WIDTH-1:0] slot_txd;
  logic [CW-1:0]        slot_txc;
  logic [OUT_WIDTH-1:0] nxt_txd;
  logic [CW-1:0]        nxt_txc;
  logic                 nxt_valid;
  logic                 nxt_half;
  logic                 nxt_in_frame;
  logic                 nxt_underrun;

  assign wr_word = '{ctrl: s_txc, data: s_txd};
  assign s_ready = !fifo_full;
  assign advance = !i_xgmii_pause || !o_xgmii_valid;

  xgmii_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (72)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .wr_en     (s_valid),
    .wr_data   (wr_word),
    .rd_en     (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_fifo_level)
  );

  // In narrow mode the head word is split into a low-lane slot and a high-lane slot.
  generate
    if (OUT_WIDTH == 32) begin : g_half
      assign slot_txd = half_sel ? head.data[63:32] : head.data[31:0];
      assign slot_txc = half_sel ? head.ctrl[7:4]   : head.ctrl[3:0];
    end else begin : g_full
      assign slot_txd = head.data;
      assign slot_txc = head.ctrl;
    end
  endgenerate

  // The head word is only popped once its last slot has been loaded, so the
  // FIFO can never run dry between the two halves of a word.
  always_comb begin
    nxt_txd      = o_xgmii_txd;
    nxt_txc      = o_xgmii_txc;
    nxt_valid    = o_xgmii_valid;
    nxt_half     = half_sel;
    nxt_in_frame = in_frame;
    nxt_underrun = 1'b0;
    pop          = 1'b0;
    if (advance) begin
      if (!fifo_empty) begin
        nxt_txd   = slot_txd;
        nxt_txc   = slot_txc;
        nxt_valid = 1'b1;
        if (OUT_WIDTH == 32) begin
          pop      = half_sel;
          nxt_half = !half_sel;
        end else begin
          pop = 1'b1;
        end
        for (int i = 0; i < CW; i++) begin
          if (slot_txc[i]) begin
            if (slot_txd[i*8 +: 8] == XGMII_START) nxt_in_frame = 1'b1;
            else if (slot_txd[i*8 +: 8] == XGMII_TERM) nxt_in_frame = 1'b0;
          end
        end
      end else if (in_frame) begin
        nxt_txd      = ERR_SLOT;
        nxt_txc      = '1;
        nxt_valid    = 1'b1;
        nxt_underrun = 1'b1;
        nxt_in_frame = 1'b0;
      end else begin
        nxt_txd   = IDLE_SLOT;
        nxt_txc   = '1;
        nxt_valid = (IDLE_FILL != 0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_xgmii_txd   <= IDLE_SLOT;
      o_xgmii_txc   <= '1;
      o_xgmii_valid <= 1'b0;
      o_underrun    <= 1'b0;
      half_sel      <= 1'b0;
      in_frame      <= 1'b0;
    end else begin
      o_xgmii_txd   <= nxt_txd;
      o_xgmii_txc   <= nxt_txc;
      o_xgmii_valid <= nxt_valid;
      o_underrun    <= nxt_underrun;
      half_sel      <= nxt_half;
      in_frame      <= nxt_in_frame;
    end
  end

endmodule
